bcs_based_comparator: RTL and testbench

- Parameterised N-bit unsigned magnitude comparator built as a cascade of identical 1-bit comparator slices (bit-cascaded slice, BCS), MSB to LSB.
- Produces combinational EQ (a == b) and GT (a > b) flags, plus registered copies for synchronous consumers.
- Used as a datapath compare primitive; the combinational path is also characterised for worst-case propagation delay.

---
 rtl/bcs_pkg.sv | 14 +
 rtl/bcs_cell.sv | 22 ++
 rtl/bcs_based_comparator.sv | 52 +++++
 tb/tb_bcs_based_comparator.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcs_pkg.sv
// Shared definitions for the bit-cascaded slice comparator: default operand
// width and the packed {eq, gt} result pair.
package bcs_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef struct packed {
    logic eq;
    logic gt;
  } cmp_res_t;

  localparam cmp_res_t CMP_RES_CLEAR = '{eq: 1'b0, gt: 1'b0};

endpackage

// File: rtl/bcs_cell.sv
// One-bit comparator slice. Written as discrete gates so each stage can be
// annotated with its own delay when the chain is characterised.
module bcs_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic eq_in,
  input  logic gt_in,
  output logic eq_out,
  output logic gt_out
);

  logic bit_eq;
  logic b_n;
  logic gt_here;

  assign bit_eq  = ~(a_i ^ b_i);
  assign b_n     = ~b_i;
  assign gt_here = eq_in & a_i & b_n;
  assign eq_out  = eq_in & bit_eq;
  assign gt_out  = gt_in | gt_here;

endmodule

// File: rtl/bcs_based_comparator.sv
// N-bit unsigned magnitude comparator: a cascade of bcs_cell slices from MSB
// to LSB, with combinational EQ/GT and registered copies.
module bcs_based_comparator
  import bcs_pkg::*;
#(
  parameter int N = DEFAULT_WIDTH
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  output logic         EQ,
  output logic         GT,
  output logic         EQ_r,
  output logic         GT_r
);

  // Chain index k carries the result seen by slice k-1; index N seeds the MSB.
  logic [N:0] eq_chain;
  logic [N:0] gt_chain;

  cmp_res_t res_q;

  assign eq_chain[N] = 1'b1;
  assign gt_chain[N] = 1'b0;

  for (genvar i = 0; i < N; i++) begin : g_slice
    bcs_cell u_cell (
      .a_i    (a[i]),
      .b_i    (b[i]),
      .eq_in  (eq_chain[i+1]),
      .gt_in  (gt_chain[i+1]),
      .eq_out (eq_chain[i]),
      .gt_out (gt_chain[i])
    );
  end

  assign EQ = eq_chain[0];
  assign GT = gt_chain[0];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      res_q <= CMP_RES_CLEAR;
    end else begin
      res_q <= '{eq: EQ, gt: GT};
    end
  end

  assign EQ_r = res_q.eq;
  assign GT_r = res_q.gt;

endmodule

// File: tb/tb_bcs_based_comparator.sv
// Self-checking bench for bcs_based_comparator at N=8, N=1 and N=16 against
// a plain arithmetic reference (a == b, a > b).
module tb_bcs_based_comparator;

  localparam int HALF = 5;

  logic clk;
  logic reset;

  logic [7:0]  a8,  b8;
  logic [0:0]  a1,  b1;
  logic [15:0] a16, b16;

  logic eq8,  gt8,  eq8_r,  gt8_r;
  logic eq1,  gt1,  eq1_r,  gt1_r;
  logic eq16, gt16, eq16_r, gt16_r;

  int checks = 0;
  int errors = 0;

  bcs_based_comparator #(.N(8)) dut8 (
    .clk(clk), .reset(reset), .a(a8), .b(b8),
    .EQ(eq8), .GT(gt8), .EQ_r(eq8_r), .GT_r(gt8_r)
  );

  bcs_based_comparator #(.N(1)) dut1 (
    .clk(clk), .reset(reset), .a(a1), .b(b1),
    .EQ(eq1), .GT(gt1), .EQ_r(eq1_r), .GT_r(gt1_r)
  );

  bcs_based_comparator #(.N(16)) dut16 (
    .clk(clk), .reset(reset), .a(a16), .b(b16),
    .EQ(eq16), .GT(gt16), .EQ_r(eq16_r), .GT_r(gt16_r)
  );

  initial clk = 1'b0;
  always #HALF clk = ~clk;

  task automatic test_reset();
    reset = 1'b0;
    a8 = 8'h05; b8 = 8'h05;
    a1 = '0; b1 = '0; a16 = '0; b16 = '0;
    #1;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      checks++;
      if (eq8_r !== 1'b0 || gt8_r !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_regs: EQ_r=%b GT_r=%b expected 0 0", eq8_r, gt8_r);
      end
      checks++;
      if (eq8 !== 1'b1 || gt8 !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold_comb: EQ=%b GT=%b expected 1 0", eq8, gt8);
      end
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (eq8_r !== 1'b1 || gt8_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: EQ_r=%b GT_r=%b expected 1 0", eq8_r, gt8_r);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [5] = '{8'h00, 8'hFF, 8'hFF, 8'h7F, 8'h80};
    logic [7:0] tb [5] = '{8'h00, 8'hFF, 8'hFE, 8'h80, 8'h7F};
    logic       te [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    logic       tg [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      a8 = ta[k]; b8 = tb[k];
      @(negedge clk);
      checks++;
      if (eq8 !== te[k] || gt8 !== tg[k]) begin
        errors++;
        $display("FAIL directed[%0d] a=%h b=%h: EQ=%b GT=%b expected %b %b",
                 k, ta[k], tb[k], eq8, gt8, te[k], tg[k]);
      end
    end
  endtask

  task automatic test_exhaustive();
    int  bad = 0;
    bit  prev_valid = 0;
    logic prev_eq, prev_gt;
    logic [7:0] ea, eb;
    for (int i = 0; i < 65536; i++) begin
      @(posedge clk); #1;
      ea = 8'(i >> 8);
      eb = 8'(i);
      a8 = ea; b8 = eb;
      @(negedge clk);
      checks++;
      if (eq8 !== (ea == eb) || gt8 !== (ea > eb) || (eq8 & gt8)) begin
        errors++;
        if (bad < 10)
          $display("FAIL exhaustive a=%h b=%h: EQ=%b GT=%b expected %b %b",
                   ea, eb, eq8, gt8, (ea == eb), (ea > eb));
        bad++;
      end
      if (prev_valid) begin
        checks++;
        if (eq8_r !== prev_eq || gt8_r !== prev_gt) begin
          errors++;
          if (bad < 10)
            $display("FAIL exhaustive_reg pair %0d: EQ_r=%b GT_r=%b expected %b %b",
                     i, eq8_r, gt8_r, prev_eq, prev_gt);
          bad++;
        end
      end
      prev_eq = (ea == eb);
      prev_gt = (ea > eb);
      prev_valid = 1;
    end
  endtask

  task automatic test_worst_delay();
    logic [7:0] seq [4] = '{8'h01, 8'h00, 8'h01, 8'h00};
    int d_eq, d_gt;
    logic x_eq, x_gt;
    b8 = 8'h00;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      a8 = seq[k];
      x_eq = (seq[k] == 8'h00);
      x_gt = (seq[k] > 8'h00);
      d_eq = HALF; d_gt = HALF;
      for (int t = 0; t < HALF; t++) begin
        if (d_eq == HALF && eq8 === x_eq) d_eq = t;
        if (d_gt == HALF && gt8 === x_gt) d_gt = t;
        if (d_eq < HALF && d_gt < HALF) break;
        #1;
      end
      checks++;
      if (d_eq >= HALF || d_gt >= HALF) begin
        errors++;
        $display("FAIL lsb_delay step %0d: eq_delay=%0d gt_delay=%0d required < %0d",
                 k, d_eq, d_gt, HALF);
      end
    end
  endtask

  task automatic test_back_to_back();
    @(posedge clk); #1;
    a8 = 8'h10; b8 = 8'h20;
    @(posedge clk); #1;
    checks++;
    if (gt8_r !== 1'b0 || eq8_r !== 1'b0) begin
      errors++;
      $display("FAIL latency_first: GT_r=%b EQ_r=%b expected 0 0", gt8_r, eq8_r);
    end
    a8 = 8'h20; b8 = 8'h10;
    @(posedge clk); #1;
    checks++;
    if (gt8_r !== 1'b1 || eq8_r !== 1'b0) begin
      errors++;
      $display("FAIL latency_second: GT_r=%b EQ_r=%b expected 1 0", gt8_r, eq8_r);
    end
  endtask

  task automatic test_reset_mid_run();
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (gt8_r !== 1'b0 || eq8_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_regs: GT_r=%b EQ_r=%b expected 0 0", gt8_r, eq8_r);
    end
    checks++;
    if (gt8 !== 1'b1 || eq8 !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_comb: GT=%b EQ=%b expected 1 0", gt8, eq8);
    end
    @(posedge clk); #1;
    checks++;
    if (gt8_r !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_hold: GT_r=%b expected 0", gt8_r);
    end
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (gt8_r !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_release: GT_r=%b expected 1", gt8_r);
    end
  endtask

  task automatic test_sweep_n1();
    int bad = 0;
    bit prev_valid = 0;
    logic prev_eq, prev_gt;
    logic [0:0] ra, rb;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      ra = 1'($urandom); rb = 1'($urandom);
      a1 = ra; b1 = rb;
      @(negedge clk);
      checks++;
      if (eq1 !== (ra == rb) || gt1 !== (ra > rb) || (eq1 & gt1)) begin
        errors++;
        if (bad < 10)
          $display("FAIL sweep_n1 a=%b b=%b: EQ=%b GT=%b expected %b %b",
                   ra, rb, eq1, gt1, (ra == rb), (ra > rb));
        bad++;
      end
      if (prev_valid) begin
        checks++;
        if (eq1_r !== prev_eq || gt1_r !== prev_gt) begin
          errors++;
          if (bad < 10)
            $display("FAIL sweep_n1_reg: EQ_r=%b GT_r=%b expected %b %b",
                     eq1_r, gt1_r, prev_eq, prev_gt);
          bad++;
        end
      end
      prev_eq = (ra == rb); prev_gt = (ra > rb); prev_valid = 1;
    end
  endtask

  task automatic test_sweep_n16();
    int bad = 0;
    bit prev_valid = 0;
    logic prev_eq, prev_gt;
    logic [15:0] ra, rb;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      ra = 16'($urandom);
      // Bias a share of pairs toward equality and near-equality.
      case ($urandom_range(0, 3))
        0: rb = ra;
        1: rb = ra ^ 16'(1 << $urandom_range(0, 15));
        default: rb = 16'($urandom);
      endcase
      a16 = ra; b16 = rb;
      @(negedge clk);
      checks++;
      if (eq16 !== (ra == rb) || gt16 !== (ra > rb) || (eq16 & gt16)) begin
        errors++;
        if (bad < 10)
          $display("FAIL sweep_n16 a=%h b=%h: EQ=%b GT=%b expected %b %b",
                   ra, rb, eq16, gt16, (ra == rb), (ra > rb));
        bad++;
      end
      if (prev_valid) begin
        checks++;
        if (eq16_r !== prev_eq || gt16_r !== prev_gt) begin
          errors++;
          if (bad < 10)
            $display("FAIL sweep_n16_reg: EQ_r=%b GT_r=%b expected %b %b",
                     eq16_r, gt16_r, prev_eq, prev_gt);
          bad++;
        end
      end
      prev_eq = (ra == rb); prev_gt = (ra > rb); prev_valid = 1;
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_exhaustive();
    test_worst_delay();
    test_back_to_back();
    test_reset_mid_run();
    test_sweep_n1();
    test_sweep_n16();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
